hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage CPU.
- Owns the PC enable and the per-latch enable/flush controls for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves load-use stalls that forwarding cannot cover, data-memory wait freezes, instruction-fetch misses, taken-branch/jump flushes and halt.
- Sits beside forwarding_unit; consumes the same ID/EX register selects.

Parameters:
- REG_W, 5, register-select width.
- CNT_W, 32, performance counter width (only used with HAZARD_PERF_EN).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- ID_rs  in  REG_W  source reg A of instruction in ID.
- ID_rt  in  REG_W  source reg B of instruction in ID.
- ID_uses_rt  in  1  ID instruction reads rt.
- EX_wsel  in  REG_W  destination of instruction in EX.
- EX_MemRead  in  1  EX instruction is a load.
- MEM_dREN  in  1  MEM-stage data read request.
- MEM_dWEN  in  1  MEM-stage data write request.
- dhit  in  1  data memory done this cycle.
- ihit  in  1  instruction fetch done this cycle.
- MEM_pc_redirect  in  1  taken branch/jump resolved in MEM.
- MEM_halt  in  1  halt instruction reached MEM.
- pc_en  out  1  PC update enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous bubble insert.
- halt  out  1  CPU halted (registered).
- stall_cycles  out  CNT_W  (HAZARD_PERF_EN only).
- flush_events  out  CNT_W  (HAZARD_PERF_EN only).

Behaviour:
- One clock CLK; RST is synchronous and active-high.
- States: RUN, LU_STALL, DWAIT, FLUSH, HALTED. Reset -> RUN, halt=0, counters=0.
- While RST high, outputs are: pc_en=0, all *_en=1, all *_flush=1.
- Other outputs are combinational from state + inputs.
- mem_req = MEM_dREN|MEM_dWEN.
- load_use = EX_MemRead & EX_wsel!=0 & (EX_wsel==ID_rs | (ID_uses_rt & EX_wsel==ID_rt)).
- Default (RUN, no hazard, ihit=1): pc_en=1, all *_en=1, all flushes 0.
- Priority order each cycle, first match wins:
  1. HALTED: pc_en=0, all *_en=0, flushes 0; only RST exits.
  2. MEM_halt & !(mem_req & !dhit): memwb_en=1, all other enables 0, pc_en=0; next HALTED; halt=1 from next edge.
  3. mem_req & !dhit (DMEM wait): freeze everything (pc_en and all *_en = 0, flushes 0); next DWAIT. Remain in DWAIT while condition holds; redirect/load_use are not evaluated while frozen. When dhit=1, evaluate rules 4-7 in the same cycle.
  4. MEM_pc_redirect: pc_en=1 (target load); ifid_flush=idex_flush=exmem_flush=1; all *_en=1; next FLUSH. A redirect overrides load_use and ihit=0 in the same cycle.
  5. load_use & state!=LU_STALL & state!=FLUSH: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1; next LU_STALL (exactly one bubble). In LU_STALL the load is in MEM and forwarding covers it; load_use is masked and next is RUN.
  6. !ihit: pc_en=0, ifid_flush=1, downstream enables 1; state unchanged, except LU_STALL/FLUSH -> RUN.
  7. Otherwise: default outputs; next RUN.
- FLUSH state: load_use masked, because ID holds a bubble. Returns to RUN after one cycle unless rule 2/3/4 applies.
- Register 0 is never a hazard source.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every cycle where pc_en=0 and state!=HALTED and RST=0.
  - flush_events increments on each rule-4 cycle.
  - Both saturate at all-ones and clear on RST.
- Undefined: both ports and counters are absent; no other behaviour changes.

Decomposition:
- cpu_types_pkg gets hazard_state_t (enum RUN, LU_STALL, DWAIT, FLUSH, HALTED) and the regbits_t select typedef.
- Interface hazard_ctrl_if has modports hc (block) and tb (bench).
- Natural sub-module: hazard_perf_ctr, a saturating counter instantiated twice under the macro.

Test Plan:
- Load-use: lw r2 in EX (EX_MemRead=1, EX_wsel=2), ID_rs=2 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle state RUN, no second stall.
- r0 and rt masking: EX_wsel=0 load with ID_rs=0 -> no stall. ID_rt match with ID_uses_rt=0 -> no stall.
- DMEM wait: MEM_dREN=1, dhit=0 for 3 cycles, then 1 -> 3 fully frozen cycles, then normal advance; with perf, stall_cycles=3.
- Redirect during load_use and ihit=0 -> pc_en=1, three flushes asserted; next cycle load_use ignored (FLUSH); flush_events=1.
- Halt: MEM_halt=1 with dhit pending 2 cycles -> freeze 2 cycles, then memwb_en only; halt=1 next edge and stays set until RST.
- RST asserted mid-DWAIT -> next edge state RUN, halt=0, counters 0; during RST pc_en=0 and all flushes=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline sequencer state and register-select type.
package cpu_types_pkg;

    localparam int REG_SEL_W = 5;

    typedef logic [REG_SEL_W-1:0] regbits_t;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        DWAIT    = 3'd2,
        FLUSH    = 3'd3,
        HALTED   = 3'd4
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of hazard_ctrl signals; hc is the block side, tb the bench side.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             rst;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic [REG_W-1:0] ex_wsel;
    logic             ex_memread;
    logic             mem_dren;
    logic             mem_dwen;
    logic             dhit;
    logic             ihit;
    logic             mem_pc_redirect;
    logic             mem_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport hc (
        input  rst, id_rs, id_rt, id_uses_rt, ex_wsel, ex_memread,
               mem_dren, mem_dwen, dhit, ihit, mem_pc_redirect, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt,
               stall_cycles, flush_events
    );

    modport tb (
        output rst, id_rs, id_rt, id_uses_rt, ex_wsel, ex_memread,
               mem_dren, mem_dwen, dhit, ihit, mem_pc_redirect, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, halt,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl_perf_ctr.sv
// Saturating event counter, cleared by synchronous reset.
module hazard_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step on inc, hold once all-ones is reached.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage CPU: PC enable plus latch enables and
// flushes for load-use stalls, DMEM waits, fetch misses, redirects and halt.
// Optional build macro HAZARD_PERF_EN adds stall/flush performance counters.
module hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_uses_rt,
    input  logic [REG_W-1:0] EX_wsel,
    input  logic             EX_MemRead,
    input  logic             MEM_dREN,
    input  logic             MEM_dWEN,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             MEM_pc_redirect,
    input  logic             MEM_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
`endif
    output logic             halt
);
    hazard_state_t state_q;
    hazard_state_t state_d;
    logic          mem_wait;
    logic          load_use;
    logic          redirect_fire;

    assign mem_wait = (MEM_dREN | MEM_dWEN) & ~dhit;
    // r0 is hardwired zero, so a load targeting it never creates a hazard.
    assign load_use = EX_MemRead && (EX_wsel != '0) &&
                      ((EX_wsel == ID_rs) || (ID_uses_rt && (EX_wsel == ID_rt)));

    // Prioritised hazard resolution: outputs and next state.
    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b1;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        redirect_fire = 1'b0;
        if (RST) begin
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
        end else if (state_q == HALTED) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (MEM_halt && !mem_wait) begin
            // Let the halt instruction retire, freeze everything upstream.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            state_d  = HALTED;
        end else if (mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            state_d  = DWAIT;
        end else if (MEM_pc_redirect) begin
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            redirect_fire = 1'b1;
            state_d       = FLUSH;
        end else if (load_use && (state_q != LU_STALL) && (state_q != FLUSH)) begin
            // One bubble: after it the load sits in MEM and forwarding covers it.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = LU_STALL;
        end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
            if ((state_q == LU_STALL) || (state_q == FLUSH)) begin
                state_d = RUN;
            end
        end else begin
            state_d = RUN;
        end
    end

    // Sequencer state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halt = (state_q == HALTED);

`ifdef HAZARD_PERF_EN
    logic stall_inc;
    assign stall_inc = ~RST & ~pc_en & (state_q != HALTED);

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    hazard_perf_ctr #(.CNT_W(CNT_W)) u_flush_ctr (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (redirect_fire),
        .count (flush_events)
    );
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios then random traffic,
// all checked against a rule-level reference model.
module tb_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int CNT_W = 4;
    localparam int M_RUN = 0, M_LU = 1, M_DW = 2, M_FL = 3, M_HALT = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic [REG_W-1:0] ID_rs, ID_rt, EX_wsel;
    logic             ID_uses_rt, EX_MemRead, MEM_dREN, MEM_dWEN, dhit, ihit;
    logic             MEM_pc_redirect, MEM_halt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush, halt;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_events;
`endif

    int total = 0;
    int bad   = 0;
    int mode  = M_RUN;
    int m_stall = 0;
    int m_flush = 0;
    int cyc_no = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .ID_uses_rt      (ID_uses_rt),
        .EX_wsel         (EX_wsel),
        .EX_MemRead      (EX_MemRead),
        .MEM_dREN        (MEM_dREN),
        .MEM_dWEN        (MEM_dWEN),
        .dhit            (dhit),
        .ihit            (ihit),
        .MEM_pc_redirect (MEM_pc_redirect),
        .MEM_halt        (MEM_halt),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
`ifdef HAZARD_PERF_EN
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
`endif
        .halt            (halt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc_no, obs, exp);
        end
    endtask

    task automatic idle();
        RST = 0; ID_rs = 0; ID_rt = 0; ID_uses_rt = 0; EX_wsel = 0; EX_MemRead = 0;
        MEM_dREN = 0; MEM_dWEN = 0; dhit = 1; ihit = 1; MEM_pc_redirect = 0; MEM_halt = 0;
    endtask

    // Apply current inputs for one cycle: check outputs mid-cycle, then advance model.
    task automatic run_cycle();
        bit hz, waitm;
        logic [7:0] exp_v, obs_v;
        int nmode;
        bit redirect_now;
        @(negedge CLK);
        hz    = EX_MemRead && EX_wsel != 0 &&
                (EX_wsel == ID_rs || (ID_uses_rt && EX_wsel == ID_rt));
        waitm = (MEM_dREN || MEM_dWEN) && !dhit;
        nmode = mode;
        redirect_now = 0;
        // vector order: pc, ifid, idex, exmem, memwb enables; ifid, idex, exmem flushes
        if (RST)                              begin exp_v = 8'b0_1111_111; nmode = M_RUN; end
        else if (mode == M_HALT)              exp_v = 8'b0_0000_000;
        else if (MEM_halt && !waitm)          begin exp_v = 8'b0_0001_000; nmode = M_HALT; end
        else if (waitm)                       begin exp_v = 8'b0_0000_000; nmode = M_DW; end
        else if (MEM_pc_redirect)             begin exp_v = 8'b1_1111_111; nmode = M_FL; redirect_now = 1; end
        else if (hz && mode != M_LU && mode != M_FL) begin exp_v = 8'b0_0111_010; nmode = M_LU; end
        else if (!ihit) begin
            exp_v = 8'b0_1111_100;
            if (mode == M_LU || mode == M_FL) nmode = M_RUN;
        end
        else                                  begin exp_v = 8'b1_1111_000; nmode = M_RUN; end
        obs_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
        check_val("ctrl", {24'd0, obs_v}, {24'd0, exp_v});
        check_val("halt", {31'd0, halt}, {31'd0, mode == M_HALT});
`ifdef HAZARD_PERF_EN
        check_val("stall_cycles", {28'd0, stall_cycles}, m_stall);
        check_val("flush_events", {28'd0, flush_events}, m_flush);
`endif
        if (RST) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!exp_v[7] && mode != M_HALT && m_stall < 15) m_stall++;
            if (redirect_now && m_flush < 15) m_flush++;
        end
        @(posedge CLK);
        #1;
        mode = nmode;
        cyc_no++;
    endtask

    initial begin
        idle(); RST = 1;
        run_cycle(); run_cycle();
        idle();
        run_cycle();
        // load-use on rs: one bubble, then no second stall
        EX_MemRead = 1; EX_wsel = 2; ID_rs = 2;
        run_cycle(); run_cycle();
        idle(); run_cycle();
        // r0 load and unused-rt matches must not stall
        EX_MemRead = 1; EX_wsel = 0; ID_rs = 0; run_cycle();
        idle(); EX_MemRead = 1; EX_wsel = 3; ID_rt = 3; ID_rs = 1; ID_uses_rt = 0; run_cycle();
        ID_uses_rt = 1; run_cycle();
        idle(); run_cycle();
        // DMEM wait three cycles then advance
        idle(); RST = 1; run_cycle(); idle();
        MEM_dREN = 1; dhit = 0; repeat (3) run_cycle();
        dhit = 1; run_cycle();
        idle(); run_cycle();
        // redirect beats load-use and fetch miss; FLUSH masks load-use next cycle
        MEM_pc_redirect = 1; EX_MemRead = 1; EX_wsel = 2; ID_rs = 2; ihit = 0; run_cycle();
        MEM_pc_redirect = 0; ihit = 1; run_cycle();
        idle(); ihit = 0; run_cycle();
        idle(); run_cycle();
        // halt with pending DMEM
        MEM_halt = 1; MEM_dREN = 1; dhit = 0; repeat (2) run_cycle();
        dhit = 1; run_cycle();
        idle(); repeat (3) run_cycle();
        // reset from HALTED, then reset mid-DWAIT
        RST = 1; run_cycle(); idle();
        MEM_dWEN = 1; dhit = 0; repeat (2) run_cycle();
        RST = 1; run_cycle(); RST = 0; run_cycle();
        idle(); run_cycle();
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            RST             = ($urandom_range(0, 49) == 0);
            ID_rs           = REG_W'($urandom_range(0, 3));
            ID_rt           = REG_W'($urandom_range(0, 3));
            EX_wsel         = REG_W'($urandom_range(0, 3));
            ID_uses_rt      = $urandom_range(0, 1) == 1;
            EX_MemRead      = $urandom_range(0, 1) == 1;
            MEM_dREN        = $urandom_range(0, 3) == 0;
            MEM_dWEN        = $urandom_range(0, 6) == 0;
            dhit            = $urandom_range(0, 9) < 6;
            ihit            = $urandom_range(0, 9) < 8;
            MEM_pc_redirect = $urandom_range(0, 9) == 0;
            MEM_halt        = $urandom_range(0, 29) == 0;
            run_cycle();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
